formula_tb: RTL and testbench

FORMULA_TB -- requirements
Module: formula_tb

---
 rtl/formula_tb_if.sv | 13 +
 rtl/formula_tb.sv | 182 ++++++++++++++++++
 tb/tb_formula_tb.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/formula_tb_if.sv
// Argument/result bus of the formula block: operands in with a strobe,
// result out with a single-cycle strobe.
interface formula_tb_if;
   logic        arg_vld;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] c;
   logic        res_vld;
   logic [31:0] res;

   modport master (output arg_vld, a, b, c, input res_vld, res);
   modport slave  (input arg_vld, a, b, c, output res_vld, res);
endinterface

// File: rtl/formula_tb.sv
// Iterative integer square-root formula engine: either the sum of three roots
// or the nested root isqrt(a + isqrt(b + isqrt(c))), built on restoring units.
module formula_tb_isqrt (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] op,
   output logic [15:0] root
);
   logic [31:0] x;
   logic [17:0] rem;
   logic [19:0] rem_sh;
   logic [17:0] trial;
   logic        ge;

   // Bring down the next two radicand bits and try setting the next root bit.
   always_comb begin
      rem_sh = {rem, x[31:30]};
      trial  = {root, 2'b01};
      ge     = (rem_sh >= {2'b00, trial});
   end

   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous, so it lives inside the clocked branch; all state uses <=.
      if (rst) begin
         x    <= '0;
         rem  <= '0;
         root <= '0;
      end else if (load) begin
         x    <= op;
         rem  <= '0;
         root <= '0;
      end else if (step) begin
         x    <= {x[29:0], 2'b00};
         rem  <= ge ? (rem_sh[17:0] - trial) : rem_sh[17:0];
         root <= {root[14:0], ge};
      end
   end
endmodule

module formula_tb #(
   parameter int formula = 1,
   parameter int impl    = 1
) (
   input  logic         clk,
   input  logic         rst,
   formula_tb_if.slave  bus
);
   localparam bit par = (formula == 1) && (impl == 2);

   typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_DONE} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;
   logic        accept, load, step, finish;
   logic [31:0] res_nxt;
   logic [31:0] res_r;
   logic        res_vld_r;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_nxt and no latch is inferred.
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (bus.arg_vld) state_nxt = S_P1;
         S_P1:    if (finish) state_nxt = par ? S_DONE : S_P2;
         S_P2:    if (finish) state_nxt = S_P3;
         S_P3:    if (finish) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // The accepting cycle doubles as the load cycle of the first pass.
   always_comb begin
      accept = 1'b0;
      load   = 1'b0;
      step   = 1'b0;
      unique case (state)
         S_IDLE: begin
            accept = bus.arg_vld;
            load   = bus.arg_vld;
         end
         S_P1:       step = 1'b1;
         S_P2, S_P3: begin
            load = (cnt == 5'd0);
            step = (cnt != 5'd0);
         end
         default: ;
      endcase
      finish = step && (cnt == 5'd16);
   end

   always_ff @(posedge clk) begin
      if (rst)                                  cnt <= '0;
      else if (accept)                          cnt <= 5'd1;
      else if (finish)                          cnt <= '0;
      else if (state inside {S_P1, S_P2, S_P3}) cnt <= cnt + 5'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_r     <= '0;
         res_vld_r <= 1'b0;
      end else begin
         res_vld_r <= (state == S_DONE);
         if (state == S_DONE) res_r <= res_nxt;
      end
   end

   assign bus.res     = res_r;
   assign bus.res_vld = res_vld_r;

   if (formula == 2) begin : g_nested
      logic [31:0] a_r, b_r, op, root_x;
      logic [15:0] root;

      always_ff @(posedge clk) begin
         if (rst) begin
            a_r <= '0;
            b_r <= '0;
         end else if (accept) begin
            a_r <= bus.a;
            b_r <= bus.b;
         end
      end

      assign root_x = {16'd0, root};

      // Each pass folds the previous root into the next operand, wrapping at 32 bits.
      always_comb begin
         if (accept)              op = bus.c;
         else if (state == S_P2)  op = b_r + root_x;
         else                     op = a_r + root_x;
      end

      formula_tb_isqrt u_sqrt (.clk(clk), .rst(rst), .load(load), .step(step), .op(op), .root(root));
      assign res_nxt = root_x;
   end else if (par) begin : g_parallel
      logic [15:0] root_a, root_b, root_c;

      formula_tb_isqrt u_sqrt_a (.clk(clk), .rst(rst), .load(load), .step(step), .op(bus.a), .root(root_a));
      formula_tb_isqrt u_sqrt_b (.clk(clk), .rst(rst), .load(load), .step(step), .op(bus.b), .root(root_b));
      formula_tb_isqrt u_sqrt_c (.clk(clk), .rst(rst), .load(load), .step(step), .op(bus.c), .root(root_c));

      assign res_nxt = {16'd0, root_a} + {16'd0, root_b} + {16'd0, root_c};
   end else begin : g_shared
      logic [31:0] b_r, c_r, acc, op, root_x;
      logic [15:0] root;

      assign root_x = {16'd0, root};

      // The finished root of the previous pass is still held during the next load cycle.
      always_ff @(posedge clk) begin
         if (rst) begin
            b_r <= '0;
            c_r <= '0;
            acc <= '0;
         end else if (accept) begin
            b_r <= bus.b;
            c_r <= bus.c;
            acc <= '0;
         end else if (load) begin
            acc <= acc + root_x;
         end
      end

      always_comb begin
         if (accept)              op = bus.a;
         else if (state == S_P2)  op = b_r;
         else                     op = c_r;
      end

      formula_tb_isqrt u_sqrt (.clk(clk), .rst(rst), .load(load), .step(step), .op(op), .root(root));
      assign res_nxt = acc + root_x;
   end
endmodule

// File: tb/tb_formula_tb.sv
// Drives all three configurations of formula_tb from one operand stream and
// compares every result and its arrival cycle with an arithmetic reference.
module tb_formula_tb;
   logic        clk = 1'b0;
   logic        rst;
   logic        arg_vld;
   logic [31:0] a, b, c;
   logic [2:0]        res_vld_o;
   logic [2:0][31:0]  res_o;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int lat [3] = '{51, 17, 51};

   typedef struct {
      int          cyc;
      logic [31:0] res;
   } pulse_t;

   pulse_t pq  [3][$];
   pulse_t exq [3][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Index 0: formula 1 shared unit, 1: formula 1 parallel units, 2: formula 2.
   for (genvar gk = 0; gk < 3; gk++) begin : g_dut
      formula_tb_if bus ();
      assign bus.arg_vld   = arg_vld;
      assign bus.a         = a;
      assign bus.b         = b;
      assign bus.c         = c;
      assign res_vld_o[gk] = bus.res_vld;
      assign res_o[gk]     = bus.res;
      formula_tb #(.formula(gk == 2 ? 2 : 1), .impl(gk == 1 ? 2 : 1)) dut (
         .clk(clk), .rst(rst), .bus(bus)
      );
   end

   always @(posedge clk) begin
      #1;
      for (int k = 0; k < 3; k++)
         if (res_vld_o[k] === 1'b1) pq[k].push_back(pulse_t'{cyc, res_o[k]});
   end

   function automatic logic [31:0] isqrt_m(logic [31:0] x);
      longint unsigned lo, hi, mid;
      lo = 0;
      hi = 65536;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= {32'd0, x}) lo = mid;
         else                         hi = mid;
      end
      return 32'(lo);
   endfunction

   function automatic logic [31:0] ref_res(int k, logic [31:0] ta, logic [31:0] tb, logic [31:0] tc);
      logic [31:0] t;
      if (k == 2) begin
         t = tb + isqrt_m(tc);
         t = ta + isqrt_m(t);
         return isqrt_m(t);
      end
      return isqrt_m(ta) + isqrt_m(tb) + isqrt_m(tc);
   endfunction

   function automatic logic [31:0] rnd32();
      logic [31:0] r;
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2: begin
            r = $urandom_range(0, 65535);
            return r * r;
         end
         default: return $urandom;
      endcase
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; returns the number of the edge that accepts.
   task automatic start(input logic [31:0] ta, input logic [31:0] tb, input logic [31:0] tc, output int acc);
      for (int k = 0; k < 3; k++) pq[k].delete();
      arg_vld = 1'b1;
      a = ta;
      b = tb;
      c = tc;
      @(negedge clk);
      acc     = cyc;
      arg_vld = 1'b0;
      a = $urandom;
      b = $urandom;
      c = $urandom;
   endtask

   task automatic expect_one(string tag, logic [31:0] ta, logic [31:0] tb, logic [31:0] tc, int acc);
      pulse_t p;
      for (int k = 0; k < 3; k++) begin
         p.cyc = -1;
         p.res = 'x;
         if (pq[k].size() > 0) p = pq[k][0];
         check($sformatf("%s_d%0d_pulses", tag, k), 32'(pq[k].size()), 32'd1);
         check($sformatf("%s_d%0d_latency", tag, k), 32'(p.cyc), 32'(acc + lat[k]));
         check($sformatf("%s_d%0d_res", tag, k), p.res, ref_res(k, ta, tb, tc));
         check($sformatf("%s_d%0d_hold", tag, k), res_o[k], ref_res(k, ta, tb, tc));
         check($sformatf("%s_d%0d_vld_low", tag, k), {31'd0, res_vld_o[k]}, 32'd0);
      end
   endtask

   initial begin
      int     acc;
      int     next_acc [3];
      int     done_n   [3];
      bit     all_done;
      bit     all_empty;
      pulse_t p, e;

      // Strobe held during reset with operands that must never be used.
      rst     = 1'b1;
      arg_vld = 1'b1;
      a = 32'd100;
      b = 32'd200;
      c = 32'd300;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_d%0d_vld", k), {31'd0, res_vld_o[k]}, 32'd0);
         check($sformatf("reset_d%0d_res", k), res_o[k], 32'd0);
      end

      // First operation accepted on the first edge after reset release.
      rst = 1'b0;
      start(32'd16, 32'd81, 32'd1, acc);
      repeat (60) @(negedge clk);
      expect_one("small", 32'd16, 32'd81, 32'd1, acc);
      check("small_shared_const", res_o[0], 32'd14);

      start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
      repeat (60) @(negedge clk);
      expect_one("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, acc);
      check("max_parallel_const", res_o[1], 32'd196605);

      start(32'd9, 32'd14, 32'd4, acc);
      repeat (60) @(negedge clk);
      expect_one("nested", 32'd9, 32'd14, 32'd4, acc);

      start(32'hFFFE_0001, 32'hFFFE_0000, 32'd1, acc);
      repeat (60) @(negedge clk);
      expect_one("square_edge", 32'hFFFE_0001, 32'hFFFE_0000, 32'd1, acc);

      // Strobe 5 cycles into the operation must be ignored.
      start(32'd5000, 32'd6000, 32'd7000, acc);
      repeat (4) @(negedge clk);
      arg_vld = 1'b1;
      a = 32'd1;
      b = 32'd1;
      c = 32'd1;
      @(negedge clk);
      arg_vld = 1'b0;
      repeat (55) @(negedge clk);
      expect_one("busy_ignore", 32'd5000, 32'd6000, 32'd7000, acc);

      // Reset 10 cycles into an operation aborts it; a fresh zero operation follows.
      start(32'd123456, 32'd654321, 32'd999999, acc);
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("abort_d%0d_res", k), res_o[k], 32'd0);
         check($sformatf("abort_d%0d_vld", k), {31'd0, res_vld_o[k]}, 32'd0);
      end
      rst = 1'b0;
      start(32'd0, 32'd0, 32'd0, acc);
      repeat (60) @(negedge clk);
      expect_one("after_abort", 32'd0, 32'd0, 32'd0, acc);

      // Strobe held high with fresh operands every cycle: each unit must take
      // one operation every N+1 cycles, results exactly N cycles later.
      for (int k = 0; k < 3; k++) begin
         pq[k].delete();
         exq[k].delete();
         next_acc[k] = cyc + 1;
         done_n[k]   = 0;
      end
      arg_vld = 1'b1;
      a = rnd32();
      b = rnd32();
      c = rnd32();
      for (int t = 0; t < 60000; t++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (arg_vld && cyc == next_acc[k]) begin
               exq[k].push_back(pulse_t'{cyc + lat[k], ref_res(k, a, b, c)});
               next_acc[k] = cyc + lat[k] + 1;
            end
            while (pq[k].size() > 0) begin
               p = pq[k].pop_front();
               e.cyc = -1;
               e.res = 'x;
               if (exq[k].size() > 0) e = exq[k].pop_front();
               check($sformatf("rnd_d%0d_latency", k), 32'(p.cyc), 32'(e.cyc));
               check($sformatf("rnd_d%0d_res", k), p.res, e.res);
               done_n[k]++;
            end
         end
         all_done  = 1'b1;
         all_empty = 1'b1;
         for (int k = 0; k < 3; k++) begin
            if (done_n[k] < 1000)    all_done  = 1'b0;
            if (exq[k].size() != 0)  all_empty = 1'b0;
         end
         if (all_done) arg_vld = 1'b0;
         if (!arg_vld && all_empty) break;
         if (arg_vld) begin
            a = rnd32();
            b = rnd32();
            c = rnd32();
         end
      end
      arg_vld = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rnd_d%0d_outstanding", k), 32'(exq[k].size()), 32'd0);
         check($sformatf("rnd_d%0d_enough", k), {31'd0, done_n[k] >= 1000}, 32'd1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
